vx_mem_responder: RTL and testbench
===================================

Name: VX_mem_responder

Overview:
- Memory-side responder (slave end) of VX_mem_bus_if.
- Backs the bus with an on-chip byte-enabled RAM, for local scratch memories and for standalone testing of cache/LSU masters without external DRAM.
- Accepts read and write requests, returns read data with fixed pipeline latency, and buffers responses so the master may backpressure rsp_ready without losing data.

Parameters:
- DATA_SIZE, 64, bytes per bus word (matches bus DATA_SIZE).
- TAG_WIDTH, 8, request/response tag width.
- ADDR_WIDTH, 16, word-address width on the bus.
- NUM_WORDS, 4096, RAM depth; power of two, at most 2^ADDR_WIDTH.
- LATENCY, 2, read accept-to-response cycles; 1..8.
- RSP_DEPTH, 4, response queue entries; at least 2.
- WRITE_ACK, 0, 1 = writes also return a response (data all zero, tag echoed).

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- bus_if, VX_mem_bus_if.slave, –, bus port; fields used:
  - req_valid, in, 1, request valid.
  - req_data.rw, in, 1, 1 = write.
  - req_data.byteen, in, DATA_SIZE, write byte enables.
  - req_data.addr, in, ADDR_WIDTH, word address.
  - req_data.data, in, DATA_SIZE*8, write data.
  - req_data.tag, in, TAG_WIDTH, request tag.
  - req_data.atype, req_data.spatial, req_data.cache_sel: in, ignored.
  - req_ready, out, 1, request accepted when valid and ready.
  - rsp_valid, out, 1, response valid.
  - rsp_data.data, out, DATA_SIZE*8, read data.
  - rsp_data.tag, out, TAG_WIDTH, echoed tag.
  - rsp_ready, in, 1, master accepts response.

Behaviour:
- Handshakes:
  - req fire = req_valid & req_ready; rsp fire = rsp_valid & rsp_ready.
  - Once asserted, rsp_valid and rsp_data stay stable until rsp fire.
- Addressing: RAM index = addr[clog2(NUM_WORDS)-1:0]; upper address bits are ignored, so accesses alias and wrap.
- Write fire:
  - Each byte i with byteen[i]=1 is written at the clock edge ending the accept cycle.
  - No response is generated unless WRITE_ACK=1.
- Read fire at cycle T:
  - RAM read happens in cycle T; a write accepted in T-1 or earlier is visible.
  - Data and tag travel a LATENCY-deep valid/data pipeline into the response queue.
  - The pipeline advances every cycle and never stalls.
- Response queue:
  - RSP_DEPTH-entry FIFO with bypass when empty.
  - With an empty queue and rsp_ready=1, rsp_valid rises in cycle T+LATENCY.
  - Order is strict: responses return in request-accept order.
- Credit flow control:
  - Counter credits, reset value RSP_DEPTH, width clog2(RSP_DEPTH+1).
  - Decrement on a response-generating req fire; increment on rsp fire; simultaneous decrement and increment leaves it unchanged.
  - req_ready = (credits != 0), independent of rw.
  - Guarantees pipeline plus queue occupancy never exceeds RSP_DEPTH, so no overflow is possible.
- Boundaries:
  - credits==0: req_ready=0 the same cycle; a rsp fire in cycle N raises req_ready in N+1 (registered credits, no combinational rsp_ready→req_ready path).
  - Queue full with a pipeline output arriving: impossible by credits; assertion required.
  - rsp_ready held low indefinitely: queue holds data, credits reach 0, requests stall, nothing is lost.
- Reset (synchronous, active-high):
  - rsp_valid=0, pipeline valids=0, queue empty, credits=RSP_DEPTH, req_ready=0 during reset and 1 from the first cycle after.
  - RAM contents are not reset.
  - Reset mid-operation discards all in-flight reads and queued responses; any write accepted before the reset edge has taken effect.
- Assertions: parameter ranges; no X on req_data.addr while req_valid=1; queue push while full never occurs.

Decomposition:
- Shared package (VX_gpu_pkg): constant RSP_CNT_W = clog2(RSP_DEPTH+1) helper. The bus req/rsp struct types come from VX_mem_bus_if.
- One sub-module: VX_mem_responder_queue, the RSP_DEPTH bypass FIFO with push, pop, full, empty.
- Byte-enabled RAM is inline (per-byte write enable generate loop).

Test Plan:
- Write addr 0x10 data 0xA5..A5 byteen all 1, then read addr 0x10 tag 0x3 at T → rsp_valid at T+2, data 0xA5..A5, tag 0x3.
- Partial write byteen=0x...01 data 0xFF onto 0x00 word, read back → byte0=0xFF, other bytes 0x00.
- Back-to-back reads tags 1,2,3,4 with rsp_ready=1 → responses in cycles T+2..T+5 with tags 1,2,3,4 in order.
- rsp_ready=0, issue 6 reads → exactly 4 accepted and req_ready=0 afterwards; raise rsp_ready → 4 responses drain, req_ready returns the cycle after the first pop.
- Read addr NUM_WORDS+5 after writing addr 5 with 0x77 → returns 0x77 (wrap).
- Reset asserted with 2 reads in flight → no rsp_valid after reset, credits=4, req_ready=1 one cycle after reset drops.

Source files
------------

// File: rtl/vx_mem_responder_pkg.sv
// Shared constants and helpers for the on-chip memory responder.
package vx_mem_responder_pkg;

    localparam int MAX_LATENCY = 8;

    // Width of a counter that must hold every value 0..depth.
    function automatic int rsp_cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/vx_mem_responder_queue.sv
// Response FIFO with empty bypass: a push into an empty queue is visible on the
// output in the same cycle and is only stored if it is not popped right away.
module vx_mem_responder_queue
    import vx_mem_responder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = rsp_cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_en, rd_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign out_valid = !empty || push;
    assign out_data  = empty ? push_data : mem_q[rd_ptr_q];

    // A bypassed entry that is consumed immediately never touches storage.
    assign wr_en = push && !(empty && pop);
    assign rd_en = pop && !empty;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);
        count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/vx_mem_responder.sv
// Slave end of the memory bus backed by a byte-enabled on-chip RAM, with a fixed
// read latency and a credit-protected response queue.
module vx_mem_responder
    import vx_mem_responder_pkg::*;
#(
    parameter int DATA_SIZE  = 64,
    parameter int TAG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_WORDS  = 4096,
    parameter int LATENCY    = 2,
    parameter int RSP_DEPTH  = 4,
    parameter int WRITE_ACK  = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    input  logic                   req_rw,
    input  logic [DATA_SIZE-1:0]   req_byteen,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [DATA_SIZE*8-1:0] req_data,
    input  logic [TAG_WIDTH-1:0]   req_tag,
    output logic                   req_ready,
    output logic                   rsp_valid,
    output logic [DATA_SIZE*8-1:0] rsp_data,
    output logic [TAG_WIDTH-1:0]   rsp_tag,
    input  logic                   rsp_ready
);
    localparam int WORD_W = DATA_SIZE * 8;
    localparam int IDX_W  = $clog2(NUM_WORDS);
    localparam int CNT_W  = rsp_cnt_width(RSP_DEPTH);
    localparam int PKT_W  = TAG_WIDTH + WORD_W;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             req_fire, rd_fire, wr_fire, rsp_gen, rsp_fire;
    logic [IDX_W-1:0] ram_idx;
    logic [CNT_W-1:0] credits_q, credits_d;

    assign req_ready = !reset && (credits_q != '0);
    assign req_fire  = req_valid && req_ready;
    assign rd_fire   = req_fire && !req_rw;
    assign wr_fire   = req_fire && req_rw;
    assign rsp_gen   = rd_fire || (wr_fire && (WRITE_ACK != 0));
    assign ram_idx   = req_addr[IDX_W-1:0];

    // RAM: one byte lane per generate block so each lane has its own write enable.
    logic [WORD_W-1:0] ram_rdata;

    for (genvar b = 0; b < DATA_SIZE; b++) begin : g_lane
        logic [7:0] lane_q [NUM_WORDS];
        logic [7:0] rdata_q;

        // NOTE: the RAM array and its read register carry no reset; contents are defined only by writes.
        always_ff @(posedge clk) begin
            if (wr_fire && req_byteen[b]) lane_q[ram_idx] <= req_data[b*8 +: 8];
            if (rd_fire) rdata_q <= lane_q[ram_idx];
        end

        assign ram_rdata[b*8 +: 8] = rdata_q;
    end

    // Stage 0 lines up tag/valid with the registered RAM read.
    logic                 s0_valid_q, s0_valid_d;
    logic                 s0_rd_q, s0_rd_d;
    logic [TAG_WIDTH-1:0] s0_tag_q, s0_tag_d;
    logic [WORD_W-1:0]    s0_data;
    logic [PKT_W-1:0]     s0_pkt;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        credits_d  = credits_q;
        s0_valid_d = rsp_gen;
        s0_rd_d    = rd_fire;
        s0_tag_d   = req_tag;
        if (rsp_gen && !rsp_fire) begin
            credits_d = credits_q - CNT_ONE;
        end else if (rsp_fire && !rsp_gen) begin
            credits_d = credits_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            credits_q  <= CNT_W'(RSP_DEPTH);
            s0_valid_q <= 1'b0;
            s0_rd_q    <= 1'b0;
        end else begin
            credits_q  <= credits_d;
            s0_valid_q <= s0_valid_d;
            s0_rd_q    <= s0_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        s0_tag_q <= s0_tag_d;
    end

    // Write acknowledgements carry all-zero data.
    assign s0_data = s0_rd_q ? ram_rdata : '0;
    assign s0_pkt  = {s0_tag_q, s0_data};

    logic             pipe_valid;
    logic [PKT_W-1:0] pipe_pkt;

    if (LATENCY > 1) begin : g_dly
        localparam int N = LATENCY - 1;
        logic [N-1:0]     valid_q, valid_d;
        logic [PKT_W-1:0] pkt_q [N];
        logic [PKT_W-1:0] pkt_d [N];

        always_comb begin
            valid_d[0] = s0_valid_q;
            pkt_d[0]   = s0_pkt;
            for (int i = 1; i < N; i++) begin
                valid_d[i] = valid_q[i-1];
                pkt_d[i]   = pkt_q[i-1];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) valid_q <= '0;
            else       valid_q <= valid_d;
        end

        always_ff @(posedge clk) begin
            pkt_q <= pkt_d;
        end

        assign pipe_valid = valid_q[N-1];
        assign pipe_pkt   = pkt_q[N-1];
    end else begin : g_nodly
        assign pipe_valid = s0_valid_q;
        assign pipe_pkt   = s0_pkt;
    end

    logic             q_valid, q_full, q_empty;
    logic [PKT_W-1:0] rsp_pkt;

    vx_mem_responder_queue #(
        .WIDTH (PKT_W),
        .DEPTH (RSP_DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (pipe_valid),
        .push_data (pipe_pkt),
        .pop       (rsp_ready),
        .out_valid (q_valid),
        .out_data  (rsp_pkt),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign rsp_valid          = q_valid && !reset;
    assign rsp_fire           = rsp_valid && rsp_ready;
    assign {rsp_tag, rsp_data} = rsp_pkt;

    param_range_a: assert property (@(posedge clk)
        (LATENCY >= 1) && (LATENCY <= MAX_LATENCY) && (RSP_DEPTH >= 2) &&
        (NUM_WORDS == (1 << IDX_W)) && (IDX_W <= ADDR_WIDTH));

    addr_known_a: assert property (@(posedge clk) disable iff (reset)
        req_valid |-> !$isunknown(req_addr));

    no_push_full_a: assert property (@(posedge clk) disable iff (reset)
        !(pipe_valid && q_full));

    queue_shows_head_a: assert property (@(posedge clk) disable iff (reset)
        !q_empty |-> q_valid);

endmodule

// File: tb/tb_vx_mem_responder.sv
// Self-checking bench: directed table, multi-cycle sequences and random traffic
// checked every cycle against a transaction-level model.
module tb_vx_mem_responder;
    localparam int DATA_SIZE  = 64;
    localparam int TAG_WIDTH  = 8;
    localparam int ADDR_WIDTH = 16;
    localparam int NUM_WORDS  = 4096;
    localparam int LATENCY    = 2;
    localparam int RSP_DEPTH  = 4;
    localparam int WRITE_ACK  = 0;
    localparam int WORD_W     = DATA_SIZE * 8;

    typedef logic [WORD_W-1:0] word_t;

    logic                  clk = 1'b0;
    logic                  reset, req_valid, req_rw, req_ready, rsp_valid, rsp_ready;
    logic [DATA_SIZE-1:0]  req_byteen;
    logic [ADDR_WIDTH-1:0] req_addr;
    word_t                 req_data, rsp_data;
    logic [TAG_WIDTH-1:0]  req_tag, rsp_tag;

    vx_mem_responder #(
        .DATA_SIZE (DATA_SIZE), .TAG_WIDTH (TAG_WIDTH), .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_WORDS (NUM_WORDS), .LATENCY (LATENCY), .RSP_DEPTH (RSP_DEPTH),
        .WRITE_ACK (WRITE_ACK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_rw     (req_rw),
        .req_byteen (req_byteen),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_tag    (req_tag),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_tag    (rsp_tag),
        .rsp_ready  (rsp_ready)
    );

    always #5 clk = ~clk;

    // Model: word-indexed memory plus the ordered list of responses still owed,
    // each tagged with the first cycle it may be presented.
    typedef struct {
        int                   arrive;
        word_t                data;
        logic [TAG_WIDTH-1:0] tag;
    } exp_rsp_t;

    exp_rsp_t exp_q[$];
    word_t    mem_m [int];

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;

    logic                 obs_valid, obs_ready;
    word_t                obs_data;
    logic [TAG_WIDTH-1:0] obs_tag;

    task automatic check(input string name, input word_t act, input word_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // One bus cycle: drive, sample, compare against the model, advance the model.
    task automatic cycle(input logic rst_i, input logic v, input logic rw,
                         input logic [DATA_SIZE-1:0] be, input logic [ADDR_WIDTH-1:0] a,
                         input word_t d, input logic [TAG_WIDTH-1:0] t, input logic rdy);
        logic  exp_ready, exp_valid;
        int    idx;
        word_t w;
        reset      = rst_i;
        req_valid  = v;
        req_rw     = rw;
        req_byteen = be;
        req_addr   = a;
        req_data   = d;
        req_tag    = t;
        rsp_ready  = rdy;
        #1;
        exp_ready = !rst_i && (exp_q.size() < RSP_DEPTH);
        exp_valid = 1'b0;
        if (!rst_i && exp_q.size() > 0) exp_valid = (exp_q[0].arrive <= cyc);
        obs_ready = req_ready;
        obs_valid = rsp_valid;
        obs_data  = rsp_data;
        obs_tag   = rsp_tag;
        check("model_req_ready", word_t'(req_ready), word_t'(exp_ready));
        check("model_rsp_valid", word_t'(rsp_valid), word_t'(exp_valid));
        if (exp_valid) begin
            check("model_rsp_data", rsp_data, exp_q[0].data);
            check("model_rsp_tag", word_t'(rsp_tag), word_t'(exp_q[0].tag));
        end
        if (rst_i) begin
            exp_q.delete();
        end else begin
            if (exp_valid && rdy) void'(exp_q.pop_front());
            if (v && exp_ready) begin
                idx = int'(a) % NUM_WORDS;
                if (rw) begin
                    w = mem_m.exists(idx) ? mem_m[idx] : '0;
                    for (int b = 0; b < DATA_SIZE; b++)
                        if (be[b]) w[b*8 +: 8] = d[b*8 +: 8];
                    mem_m[idx] = w;
                    if (WRITE_ACK != 0) exp_q.push_back('{cyc + LATENCY, '0, t});
                end else begin
                    exp_q.push_back('{cyc + LATENCY, mem_m[idx], t});
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, rdy);
    endtask

    task automatic wr(input logic [ADDR_WIDTH-1:0] a, input logic [DATA_SIZE-1:0] be, input word_t d);
        cycle(1'b0, 1'b1, 1'b1, be, a, d, '0, 1'b1);
    endtask

    task automatic rd(input logic [ADDR_WIDTH-1:0] a, input logic [TAG_WIDTH-1:0] t, input logic rdy);
        cycle(1'b0, 1'b1, 1'b0, '0, a, '0, t, rdy);
    endtask

    function automatic word_t rand_word();
        word_t w;
        for (int i = 0; i < WORD_W / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    typedef struct {
        logic [ADDR_WIDTH-1:0] waddr;
        logic [DATA_SIZE-1:0]  be;
        word_t                 wdata;
        logic [ADDR_WIDTH-1:0] raddr;
        logic [TAG_WIDTH-1:0]  tag;
        word_t                 exp;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int acc;
        logic [DATA_SIZE-1:0] all_be;
        all_be = '1;
        vecs[0] = '{16'h0010, all_be, {64{8'hA5}}, 16'h0010, 8'h03, {64{8'hA5}}};
        vecs[1] = '{16'h0020, 64'h1, {64{8'hFF}}, 16'h0020, 8'h04, 512'hFF};
        vecs[2] = '{16'h0005, all_be, 512'h77, 16'h1005, 8'h05, 512'h77};
        vecs[3] = '{16'h0030, 64'hF0, {64{8'h11}}, 16'h0030, 8'h06, 512'h11111111_00000000};
        vecs[4] = '{16'hFFFF, all_be, 512'h0123456789ABCDEF, 16'h0FFF, 8'h07, 512'h0123456789ABCDEF};

        reset = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_byteen = '0;
        req_addr = '0; req_data = '0; req_tag = '0; rsp_ready = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, 1'b1);
            check("reset_req_ready", word_t'(obs_ready), word_t'(0));
            check("reset_rsp_valid", word_t'(obs_valid), word_t'(0));
        end
        idle(1'b1);
        check("post_reset_ready", word_t'(obs_ready), word_t'(1));

        for (int i = 0; i < 5; i++) wr(vecs[i].waddr, all_be, '0);
        for (int i = 0; i < 5; i++) begin
            wr(vecs[i].waddr, vecs[i].be, vecs[i].wdata);
            rd(vecs[i].raddr, vecs[i].tag, 1'b1);
            check("vec_accept_cycle_valid", word_t'(obs_valid), word_t'(0));
            for (int k = 1; k < LATENCY; k++) begin
                idle(1'b1);
                check("vec_early_valid", word_t'(obs_valid), word_t'(0));
            end
            idle(1'b1);
            check("vec_valid", word_t'(obs_valid), word_t'(1));
            check("vec_data", obs_data, vecs[i].exp);
            check("vec_tag", word_t'(obs_tag), word_t'(vecs[i].tag));
        end

        // Back-to-back reads come out on consecutive cycles in order.
        for (int i = 0; i < 8; i++) begin
            if (i < 4) rd(16'h0010, 8'(i + 1), 1'b1);
            else       idle(1'b1);
            if (i >= 2 && i <= 5) begin
                check("b2b_valid", word_t'(obs_valid), word_t'(1));
                check("b2b_tag", word_t'(obs_tag), word_t'(i - 1));
            end
        end

        // Backpressure: credits run out after RSP_DEPTH accepts.
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            rd(16'h0010, 8'(8'h10 + i), 1'b0);
            acc += int'(obs_ready);
        end
        check("bp_accepted", word_t'(acc), word_t'(4));
        check("bp_ready_low", word_t'(obs_ready), word_t'(0));
        idle(1'b1);
        check("bp_pop_cycle_ready", word_t'(obs_ready), word_t'(0));
        check("bp_pop_valid", word_t'(obs_valid), word_t'(1));
        check("bp_tag", word_t'(obs_tag), word_t'(8'h10));
        for (int i = 1; i < 4; i++) begin
            idle(1'b1);
            if (i == 1) check("bp_ready_after_pop", word_t'(obs_ready), word_t'(1));
            check("bp_tag", word_t'(obs_tag), word_t'(8'h10 + i));
        end
        idle(1'b1);
        check("bp_drained", word_t'(obs_valid), word_t'(0));

        // Reset with reads in flight discards them and restores full credit.
        rd(16'h0010, 8'h21, 1'b1);
        rd(16'h0010, 8'h22, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            if (i == 0) check("rst_mid_ready", word_t'(obs_ready), word_t'(1));
            check("rst_mid_no_rsp", word_t'(obs_valid), word_t'(0));
        end
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            rd(16'h0005, 8'(8'h30 + i), 1'b0);
            acc += int'(obs_ready);
        end
        check("rst_mid_credits", word_t'(acc), word_t'(RSP_DEPTH));
        for (int i = 0; i < 6; i++) idle(1'b1);

        // Random traffic on a small aliased address set.
        for (int i = 0; i < 8; i++) wr(16'h0040 + 16'(i), all_be, rand_word());
        for (int n = 0; n < 400; n++) begin
            logic                  v, rw, rdy, rst_r;
            logic [ADDR_WIDTH-1:0] a;
            a     = {4'($urandom), 12'h040 + 12'($urandom_range(0, 7))};
            v     = ($urandom_range(0, 99) < 60);
            rw    = ($urandom_range(0, 2) == 0);
            rdy   = ($urandom_range(0, 99) < 70);
            rst_r = ($urandom_range(0, 199) == 0);
            cycle(rst_r, v, rw, {$urandom, $urandom}, a, rand_word(), 8'($urandom), rdy);
        end
        for (int i = 0; i < 12; i++) idle(1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
